// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: round-robin arbiter that shares one scoreboard writeback
// port between NR_REQ functional-unit result streams. Each requester owns a
// one-entry holding buffer; one buffered result is granted per cycle.
// Optional feature macro: WB_ARB_PERF_EN (saturating arbitration-conflict counter).
module wb_port_arbiter #(
    parameter int NR_REQ        = 3,
    parameter int TRANS_ID_BITS = 3,
    parameter int XLEN          = 64
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic                                flush_i,
    input  logic [NR_REQ-1:0]                   req_valid_i,
    output logic [NR_REQ-1:0]                   req_ready_o,
    input  logic [NR_REQ-1:0][TRANS_ID_BITS-1:0] req_trans_id_i,
    input  logic [NR_REQ-1:0][XLEN-1:0]         req_data_i,
    input  logic [NR_REQ-1:0]                   req_ex_valid_i,
    output logic                                wb_valid_o,
    output logic [TRANS_ID_BITS-1:0]            wb_trans_id_o,
    output logic [XLEN-1:0]                     wb_data_o,
    output logic                                wb_ex_valid_o,
    output logic [NR_REQ-1:0]                   wb_grant_o,
    output logic [31:0]                         conflict_cnt_o
);

    localparam int PTR_W = (NR_REQ > 1) ? $clog2(NR_REQ) : 1;

    // Holding buffers and round-robin pointer
    logic [NR_REQ-1:0]                    r_buf_valid;
    logic [NR_REQ-1:0][TRANS_ID_BITS-1:0] r_buf_id;
    logic [NR_REQ-1:0][XLEN-1:0]          r_buf_data;
    logic [NR_REQ-1:0]                    r_buf_ex;
    logic [PTR_W-1:0]                     r_rr;

    logic [NR_REQ-1:0] w_grant;
    logic [NR_REQ-1:0] w_accept;
    logic [NR_REQ-1:0] w_ready;
    logic [PTR_W-1:0]  w_grant_idx;
    logic              w_any_grant;

    // Round-robin search starting at r_rr; a flush suppresses any grant
    always_comb begin
        int idx;
        w_grant     = '0;
        w_grant_idx = '0;
        w_any_grant = 1'b0;
        idx         = 0;
        if (!flush_i) begin
            for (int k = 0; k < NR_REQ; k++) begin
                idx = int'(r_rr) + k;
                if (idx >= NR_REQ) begin
                    idx = idx - NR_REQ;
                end
                if (!w_any_grant && r_buf_valid[idx]) begin
                    w_any_grant      = 1'b1;
                    w_grant[idx]     = 1'b1;
                    w_grant_idx      = PTR_W'(idx);
                end
            end
        end
    end

    // A buffer can take a new result when empty or being drained this cycle
    always_comb begin
        w_ready = '0;
        if (!rst_i && !flush_i) begin
            w_ready = ~r_buf_valid | w_grant;
        end
        w_accept = req_valid_i & w_ready;
    end

    assign req_ready_o = w_ready;
    assign wb_valid_o  = (|r_buf_valid) & ~flush_i;
    assign wb_grant_o  = w_grant;

    // AND-OR mux of the granted buffer; all-zero when nothing is granted
    always_comb begin
        wb_trans_id_o = '0;
        wb_data_o     = '0;
        wb_ex_valid_o = 1'b0;
        for (int i = 0; i < NR_REQ; i++) begin
            if (w_grant[i]) begin
                wb_trans_id_o = wb_trans_id_o | r_buf_id[i];
                wb_data_o     = wb_data_o | r_buf_data[i];
                wb_ex_valid_o = wb_ex_valid_o | r_buf_ex[i];
            end
        end
    end

    // Control state: buffer occupancy and pointer; reset and flush drop everything
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_buf_valid <= '0;
            r_rr        <= '0;
        end else if (flush_i) begin
            r_buf_valid <= '0;
        end else begin
            r_buf_valid <= (r_buf_valid & ~w_grant) | w_accept;
            if (w_any_grant) begin
                r_rr <= (w_grant_idx == PTR_W'(NR_REQ - 1)) ? '0 : w_grant_idx + PTR_W'(1);
            end
        end
    end

    // Payload capture; qualified by occupancy so it needs no reset
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NR_REQ; i++) begin
            if (w_accept[i]) begin
                r_buf_id[i]   <= req_trans_id_i[i];
                r_buf_data[i] <= req_data_i[i];
                r_buf_ex[i]   <= req_ex_valid_i[i];
            end
        end
    end

`ifdef WB_ARB_PERF_EN
    logic [31:0] r_conflict_cnt;
    logic        w_conflict;

    assign w_conflict = ($countones(r_buf_valid) > 1) && !flush_i;

    // Saturating count of cycles with two or more results competing
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_conflict_cnt <= '0;
        end else if (w_conflict && (r_conflict_cnt != 32'hFFFF_FFFF)) begin
            r_conflict_cnt <= r_conflict_cnt + 32'd1;
        end
    end

    assign conflict_cnt_o = r_conflict_cnt;
`else
    assign conflict_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: scoreboard bench for wb_port_arbiter (NR_REQ=3).
module tb_wb_port_arbiter;

    localparam int NR  = 3;
    localparam int IDW = 3;
    localparam int XW  = 64;
`ifdef WB_ARB_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic                    clk_i = 1'b0;
    logic                    rst_i;
    logic                    flush_i;
    logic [NR-1:0]           req_valid_i;
    logic [NR-1:0]           req_ready_o;
    logic [NR-1:0][IDW-1:0]  req_trans_id_i;
    logic [NR-1:0][XW-1:0]   req_data_i;
    logic [NR-1:0]           req_ex_valid_i;
    logic                    wb_valid_o;
    logic [IDW-1:0]          wb_trans_id_o;
    logic [XW-1:0]           wb_data_o;
    logic                    wb_ex_valid_o;
    logic [NR-1:0]           wb_grant_o;
    logic [31:0]             conflict_cnt_o;

    wb_port_arbiter #(.NR_REQ(NR), .TRANS_ID_BITS(IDW), .XLEN(XW)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .flush_i        (flush_i),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_trans_id_i (req_trans_id_i),
        .req_data_i     (req_data_i),
        .req_ex_valid_i (req_ex_valid_i),
        .wb_valid_o     (wb_valid_o),
        .wb_trans_id_o  (wb_trans_id_o),
        .wb_data_o      (wb_data_o),
        .wb_ex_valid_o  (wb_ex_valid_o),
        .wb_grant_o     (wb_grant_o),
        .conflict_cnt_o (conflict_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [IDW-1:0] id;
        logic [XW-1:0]  data;
        logic           ex;
        logic [NR-1:0]  gnt;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] pay(input int r, input logic [IDW-1:0] id);
        return {8'(r + 1), 53'h0, id};
    endfunction

    function automatic logic [31:0] ecnt(input logic [31:0] v);
        return PERF ? v : 32'h0;
    endfunction

    task automatic push(input logic [IDW-1:0] id, input logic [XW-1:0] d, input logic ex,
                        input logic [NR-1:0] g);
        exp_t t;
        t.id = id; t.data = d; t.ex = ex; t.gnt = g;
        sb.push_back(t);
    endtask

    task automatic drv(input int r, input logic [IDW-1:0] id, input logic [XW-1:0] d,
                       input logic ex);
        req_valid_i[r]    = 1'b1;
        req_trans_id_i[r] = id;
        req_data_i[r]     = d;
        req_ex_valid_i[r] = ex;
    endtask

    task automatic clr();
        req_valid_i    = '0;
        req_ex_valid_i = '0;
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle(input int n);
        clr();
        for (int i = 0; i < n; i++) step();
    endtask

    // Scoreboard monitor: every writeback must match the next expected result
    always @(negedge clk_i) begin
        if (!rst_i && wb_valid_o) begin
            if (sb.size() == 0) begin
                check("wb_unexpected_valid", 64'(wb_valid_o), 64'h0);
            end else begin
                e = sb.pop_front();
                check("wb_id",    64'(wb_trans_id_o), 64'(e.id));
                check("wb_data",  wb_data_o,          e.data);
                check("wb_ex",    64'(wb_ex_valid_o), 64'(e.ex));
                check("wb_grant", 64'(wb_grant_o),    64'(e.gnt));
            end
        end
    end

    initial begin
        rst_i = 1'b1; flush_i = 1'b0;
        req_valid_i = '0; req_trans_id_i = '0; req_data_i = '0; req_ex_valid_i = '0;

        // Reset, two cycles
        step();
        @(negedge clk_i);
        check("rst_ready",   64'(req_ready_o),    64'h0);
        check("rst_wbvalid", 64'(wb_valid_o),     64'h0);
        check("rst_wbid",    64'(wb_trans_id_o),  64'h0);
        check("rst_wbdata",  wb_data_o,           64'h0);
        check("rst_wbex",    64'(wb_ex_valid_o),  64'h0);
        check("rst_grant",   64'(wb_grant_o),     64'h0);
        check("rst_cnt",     64'(conflict_cnt_o), 64'h0);
        step();
        rst_i = 1'b0;
        @(negedge clk_i);
        check("post_rst_ready", 64'(req_ready_o), 64'h7);

        // 1: single requester streaming IDs 1,2,3
        step();
        for (int k = 1; k <= 3; k++) begin
            clr();
            drv(0, IDW'(k), pay(0, IDW'(k)), 1'b0);
            push(IDW'(k), pay(0, IDW'(k)), 1'b0, 3'b001);
            @(negedge clk_i);
            check("s1_ready0", 64'(req_ready_o[0]), 64'h1);
            step();
        end
        clr();
        @(negedge clk_i);
        check("s1_ready0_tail", 64'(req_ready_o[0]), 64'h1);
        step();
        idle(2);
        // Move pointer from 1 back to 0 by granting requester 2
        drv(2, 3'd0, pay(2, 3'd0), 1'b0);
        push(3'd0, pay(2, 3'd0), 1'b0, 3'b100);
        step();
        idle(3);

        // 2: simultaneous requests, rr=0
        drv(0, 3'd4, pay(0, 3'd4), 1'b0);
        drv(1, 3'd5, pay(1, 3'd5), 1'b0);
        drv(2, 3'd6, pay(2, 3'd6), 1'b0);
        push(3'd4, pay(0, 3'd4), 1'b0, 3'b001);
        push(3'd5, pay(1, 3'd5), 1'b0, 3'b010);
        push(3'd6, pay(2, 3'd6), 1'b0, 3'b100);
        step();
        clr();
        @(negedge clk_i);
        check("s2_ready2_c1", 64'(req_ready_o[2]), 64'h0);
        step();
        @(negedge clk_i);
        check("s2_ready2_c2", 64'(req_ready_o[2]), 64'h0);
        step();
        @(negedge clk_i);
        check("s2_ready2_c3", 64'(req_ready_o[2]), 64'h1);
        step();
        @(negedge clk_i);
        check("s2_cnt", 64'(conflict_cnt_o), 64'(ecnt(32'd2)));
        idle(2);

        // 3: requesters 0 and 2 together, then 0 and 1 to confirm rr wrapped to 0
        drv(0, 3'd1, pay(0, 3'd1), 1'b0);
        drv(2, 3'd2, pay(2, 3'd2), 1'b0);
        push(3'd1, pay(0, 3'd1), 1'b0, 3'b001);
        push(3'd2, pay(2, 3'd2), 1'b0, 3'b100);
        step();
        idle(3);
        drv(1, 3'd5, pay(1, 3'd5), 1'b0);
        drv(0, 3'd3, pay(0, 3'd3), 1'b0);
        push(3'd3, pay(0, 3'd3), 1'b0, 3'b001);
        push(3'd5, pay(1, 3'd5), 1'b0, 3'b010);
        step();
        idle(3);
        @(negedge clk_i);
        check("s3_cnt", 64'(conflict_cnt_o), 64'(ecnt(32'd4)));
        step();

        // 4: exception pass-through
        drv(1, 3'd7, 64'hDEAD, 1'b1);
        push(3'd7, 64'hDEAD, 1'b1, 3'b010);
        step();
        idle(3);

        // 5: flush with all buffers occupied
        drv(0, 3'd1, pay(0, 3'd1), 1'b0);
        drv(1, 3'd2, pay(1, 3'd2), 1'b0);
        drv(2, 3'd3, pay(2, 3'd3), 1'b0);
        step();
        clr();
        flush_i = 1'b1;
        @(negedge clk_i);
        check("s5_flush_wbvalid", 64'(wb_valid_o),  64'h0);
        check("s5_flush_grant",   64'(wb_grant_o),  64'h0);
        check("s5_flush_ready",   64'(req_ready_o), 64'h0);
        step();
        flush_i = 1'b0;
        @(negedge clk_i);
        check("s5_after_wbvalid", 64'(wb_valid_o),     64'h0);
        check("s5_after_ready",   64'(req_ready_o),    64'h7);
        check("s5_cnt",           64'(conflict_cnt_o), 64'(ecnt(32'd4)));
        step();
        idle(2);

        // 6: reset mid-operation with buffers full
        drv(0, 3'd4, pay(0, 3'd4), 1'b0);
        drv(1, 3'd5, pay(1, 3'd5), 1'b0);
        drv(2, 3'd6, pay(2, 3'd6), 1'b0);
        step();
        clr();
        rst_i = 1'b1;
        @(negedge clk_i);
        check("s6_rst_ready", 64'(req_ready_o), 64'h0);
        step();
        rst_i = 1'b0;
        @(negedge clk_i);
        check("s6_wbvalid", 64'(wb_valid_o),     64'h0);
        check("s6_wbid",    64'(wb_trans_id_o),  64'h0);
        check("s6_wbdata",  wb_data_o,           64'h0);
        check("s6_wbex",    64'(wb_ex_valid_o),  64'h0);
        check("s6_grant",   64'(wb_grant_o),     64'h0);
        check("s6_cnt",     64'(conflict_cnt_o), 64'h0);
        check("s6_ready",   64'(req_ready_o),    64'h7);
        step();
        idle(2);

        // 7: three conflict cycles; counter preloaded near saturation when built
        drv(0, 3'd1, pay(0, 3'd1), 1'b0);
        drv(1, 3'd2, pay(1, 3'd2), 1'b0);
        drv(2, 3'd3, pay(2, 3'd3), 1'b0);
        push(3'd1, pay(0, 3'd1), 1'b0, 3'b001);
        push(3'd2, pay(1, 3'd2), 1'b0, 3'b010);
        push(3'd3, pay(2, 3'd3), 1'b0, 3'b100);
`ifdef WB_ARB_PERF_EN
        force dut.r_conflict_cnt = 32'hFFFF_FFFE;
        @(negedge clk_i);
        release dut.r_conflict_cnt;
`endif
        step();
        clr();
        drv(0, 3'd4, pay(0, 3'd4), 1'b0);
        push(3'd4, pay(0, 3'd4), 1'b0, 3'b001);
        @(negedge clk_i);
        check("s7_ready_c1", 64'(req_ready_o), 64'h1);
        step();
        clr();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i);
            check("s7_cnt_sat", 64'(conflict_cnt_o), 64'(ecnt(32'hFFFF_FFFF)));
            step();
        end
        idle(3);

        check("sb_drain", 64'(sb.size()), 64'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
